// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline hazard inputs and stage-register controls.
// The optional performance counters appear only when PIPE_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if;
  localparam int unsigned REG_W = 5;

  logic             ex_mem_re;
  logic [REG_W-1:0] ex_rd;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             mem_wb_write;
  logic             pc_reset;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       ctrl_state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      flush_count;
`endif

  // Pipeline side: drives hazard information, consumes the stage controls.
  modport master (
    output ex_mem_re, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           pc_reset, if_id_flush, id_ex_bubble, ctrl_state
`ifdef PIPE_PERF_CNT_EN
  , input  stall_cycles, flush_count
`endif
  );

  // Controller side.
  modport slave (
    input  ex_mem_re, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           pc_reset, if_id_flush, id_ex_bubble, ctrl_state
`ifdef PIPE_PERF_CNT_EN
  , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: boot sequencing, memory stalls, branch flushes, load-use stalls.
// Optional PIPE_PERF_CNT_EN adds saturating stall_cycles / flush_count counters.
module pipe_hazard_ctrl (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    BOOT     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] boot_cnt, boot_cnt_nxt;
  logic       lu_mask, lu_mask_nxt;

  logic mem_stall;
  logic load_use;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic pc_reset, if_id_flush, id_ex_bubble;

  // mem_ready only matters while a request is outstanding.
  assign mem_stall = hz.mem_req && !hz.mem_ready;

  assign load_use = hz.ex_mem_re && (hz.ex_rd != 5'd0) &&
                    ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                     (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      boot_cnt <= 2'd0;
      lu_mask  <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      lu_mask  <= lu_mask_nxt;
    end
  end

  // lu_mask keeps an unchanged hazard from stalling a second consecutive cycle.
  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    lu_mask_nxt  = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    pc_reset     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;

    unique case (state)
      BOOT: begin
        pc_reset     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        pc_write     = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        if (boot_cnt == 2'd1) begin
          boot_cnt_nxt = 2'd0;
          state_nxt    = RUN;
        end else begin
          boot_cnt_nxt = boot_cnt + 2'd1;
        end
      end

      RUN: begin
        if (mem_stall) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b00000;
          state_nxt = MEM_WAIT;
        end else if (hz.branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_nxt    = FLUSH;
        end else if (load_use && !lu_mask) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          lu_mask_nxt  = 1'b1;
        end
      end

      MEM_WAIT: begin
        if (mem_stall) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b00000;
        end else if (hz.branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          state_nxt    = FLUSH;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          lu_mask_nxt  = 1'b1;
          state_nxt    = RUN;
        end else begin
          state_nxt = RUN;
        end
      end

      FLUSH: begin
        if (mem_stall) begin
          {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = 5'b00000;
          state_nxt = MEM_WAIT;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.id_ex_write  = id_ex_write;
  assign hz.ex_mem_write = ex_mem_write;
  assign hz.mem_wb_write = mem_wb_write;
  assign hz.pc_reset     = pc_reset;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.ctrl_state   = state;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;

  // Flush events are exactly the cycles asserting if_id_flush outside BOOT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if ((state != BOOT) && !pc_write && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if ((state != BOOT) && if_id_flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_count  = flush_count;
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected controls, a monitor checks them.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz();
  pipe_hazard_ctrl dut (.clk(clk), .reset(reset), .hz(hz));

  localparam logic [4:0] W_ALL  = 5'b11111;
  localparam logic [4:0] W_NONE = 5'b00000;
  localparam logic [4:0] W_LU   = 5'b00111;
  localparam logic [4:0] W_BOOT = 5'b01100;

  // Packed expectation: {state[1:0], pc,if_id,id_ex,ex_mem,mem_wb writes, pc_reset, flush, bubble}
  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  event probe_ev;
`ifdef PIPE_PERF_CNT_EN
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;
`endif

  task automatic push_exp(input string name, input logic [1:0] st, input logic [4:0] wr,
                          input logic pcr, input logic fl, input logic bb);
    exp_t e;
    e.name = name;
    e.v    = {st, wr, pcr, fl, bb};
    sb.push_back(e);
  endtask

  task automatic step(input string name, input logic rst,
                      input logic re, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic br, input logic mq, input logic mr,
                      input logic [1:0] st, input logic [4:0] wr,
                      input logic pcr, input logic fl, input logic bb);
    @(posedge clk);
    #1;
    reset           = rst;
    hz.ex_mem_re    = re;
    hz.ex_rd        = rd;
    hz.id_rs1       = rs1;
    hz.id_rs2       = rs2;
    hz.id_uses_rs1  = u1;
    hz.id_uses_rs2  = u2;
    hz.branch_taken = br;
    hz.mem_req      = mq;
    hz.mem_ready    = mr;
    push_exp(name, st, wr, pcr, fl, bb);
  endtask

  task automatic idle(input string name, input logic rst, input logic [1:0] st,
                      input logic [4:0] wr, input logic pcr, input logic fl, input logic bb);
    step(name, rst, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, st, wr, pcr, fl, bb);
  endtask

  // Monitor: outputs are combinational, so they are sampled mid-cycle (negedge) or on a probe.
  initial begin
    exp_t       e;
    logic [9:0] got;
    forever begin
      @(negedge clk or probe_ev);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {hz.ctrl_state, hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
               hz.mem_wb_write, hz.pc_reset, hz.if_id_flush, hz.id_ex_bubble};
        checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got state=%b writes=%b rst/flush/bubble=%b, expected state=%b writes=%b rst/flush/bubble=%b",
                   e.name, got[9:8], got[7:3], got[2:0], e.v[9:8], e.v[7:3], e.v[2:0]);
        end
`ifdef PIPE_PERF_CNT_EN
        if (e.v[9:8] != 2'b00 && !e.v[7]) exp_stall++;
        if (e.v[9:8] != 2'b00 && e.v[1])  exp_flush++;
`endif
      end
    end
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset           = 1'b1;
    hz.ex_mem_re    = 1'b0;
    hz.ex_rd        = 5'd0;
    hz.id_rs1       = 5'd0;
    hz.id_rs2       = 5'd0;
    hz.id_uses_rs1  = 1'b0;
    hz.id_uses_rs2  = 1'b0;
    hz.branch_taken = 1'b0;
    hz.mem_req      = 1'b0;
    hz.mem_ready    = 1'b0;

    // Reset and boot sequence: 00, 00, 01 after release.
    idle("rst_hold", 1'b1, 2'b00, W_BOOT, 1'b1, 1'b1, 1'b1);
    idle("boot0",    1'b0, 2'b00, W_BOOT, 1'b1, 1'b1, 1'b1);
    idle("boot1",    1'b0, 2'b00, W_BOOT, 1'b1, 1'b1, 1'b1);
    idle("run_idle", 1'b0, 2'b01, W_ALL,  1'b0, 1'b0, 1'b0);

    // Load-use detection.
    step("lu_rs2",   1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, W_LU,  1'b0, 1'b0, 1'b1);
    step("lu_once",  1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, W_ALL, 1'b0, 1'b0, 1'b0);
    step("lu_rd0",   1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, W_ALL, 1'b0, 1'b0, 1'b0);
    step("lu_rs1",   1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, W_LU,  1'b0, 1'b0, 1'b1);
    idle("run2",     1'b0, 2'b01, W_ALL, 1'b0, 1'b0, 1'b0);
    step("lu_nouse", 1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, W_ALL, 1'b0, 1'b0, 1'b0);

    // Memory stall: four write-frozen cycles, then release.
    step("mem_stall", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, W_NONE, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("mem_wait", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, W_NONE, 1'b0, 1'b0, 1'b0);
    step("mem_done",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, W_ALL, 1'b0, 1'b0, 1'b0);
    step("rdy_noreq", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, W_ALL, 1'b0, 1'b0, 1'b0);

    // Branch wins over load-use; FLUSH masks both.
    step("br_lu",      1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, W_ALL, 1'b0, 1'b1, 1'b1);
    step("flush_mask", 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, W_ALL, 1'b0, 1'b0, 1'b0);
    idle("after_flush", 1'b0, 2'b01, W_ALL, 1'b0, 1'b0, 1'b0);

    // Memory stall wins over branch; branch applied when memory completes.
    step("ms_over_br", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, W_NONE, 1'b0, 1'b0, 1'b0);
    step("mw_br_ign",  1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, W_NONE, 1'b0, 1'b0, 1'b0);
    step("mw_br_done", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, W_ALL,  1'b0, 1'b1, 1'b1);
    idle("flush_state", 1'b0, 2'b11, W_ALL, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while in FLUSH, checked before any clock edge.
    @(negedge clk);
    #2;
    reset = 1'b1;
`ifdef PIPE_PERF_CNT_EN
    exp_stall = 0;
    exp_flush = 0;
`endif
    #1;
    push_exp("async_rst", 2'b00, W_BOOT, 1'b1, 1'b1, 1'b1);
    ->probe_ev;

    idle("rst_hold2", 1'b1, 2'b00, W_BOOT, 1'b1, 1'b1, 1'b1);
    idle("reboot0",   1'b0, 2'b00, W_BOOT, 1'b1, 1'b1, 1'b1);
    idle("reboot1",   1'b0, 2'b00, W_BOOT, 1'b1, 1'b1, 1'b1);
    idle("rerun",     1'b0, 2'b01, W_ALL,  1'b0, 1'b0, 1'b0);

    // Load-use applied on memory completion, then masked for one cycle.
    step("ms2",       1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, W_NONE, 1'b0, 1'b0, 1'b0);
    step("mw_lu",     1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, W_LU,   1'b0, 1'b0, 1'b1);
    step("lu_masked", 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, W_ALL,  1'b0, 1'b0, 1'b0);

    // Memory stall arriving during FLUSH.
    step("br2",        1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, W_ALL,  1'b0, 1'b1, 1'b1);
    step("fl_ms",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, W_NONE, 1'b0, 1'b0, 1'b0);
    step("fl_mw",      1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, W_NONE, 1'b0, 1'b0, 1'b0);
    step("fl_mw_done", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, W_ALL,  1'b0, 1'b0, 1'b0);
    idle("end_run",    1'b0, 2'b01, W_ALL, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

`ifdef PIPE_PERF_CNT_EN
    @(posedge clk);
    #1;
    checks++;
    if (hz.stall_cycles !== 32'(exp_stall)) begin
      failures++;
      $display("FAIL stall_cycles: got %0d, expected %0d", hz.stall_cycles, exp_stall);
    end
    checks++;
    if (hz.flush_count !== 32'(exp_flush)) begin
      failures++;
      $display("FAIL flush_count: got %0d, expected %0d", hz.flush_count, exp_flush);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
